// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage data-memory access sequencer. Takes the memory control
//            fields from the EX/MEM register, runs a req/ack handshake with a
//            variable-latency data memory, steers byte lanes for stores,
//            extracts and extends load data, and stalls IF..EX/MEM until the
//            access has completed.
// Ports    : clk, reset         - clock (rising edge), sync active-high reset
//            mem_enable/rw/size/se/addr/wdata - EX/MEM access request fields
//            dm_rdata, dm_ack   - memory read word and completion strobe
//            dm_req/we/addr/wdata/be - registered memory request bus
//            load_data, load_valid  - formatted load result (valid in DONE)
//            stall              - combinational pipeline freeze
//            misalign_err       - one-cycle pulse on a misaligned request
//            timeout_err        - one-cycle pulse on an aborted access
// Config   : define MEM_TIMEOUT_EN to abort an ACCESS after TIMEOUT_CYCLES
//            cycles without ack; otherwise ACCESS waits indefinitely and
//            timeout_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  input  logic        mem_se,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_se;
  logic        r_rw;

  logic        w_misaligned;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane_shift;
  logic [31:0] w_load_fmt;
  logic        w_timeout;

  // Request decode (sizes 10 and 11 both behave as a word)
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = mem_wdata;
    case (mem_size)
      c_SIZE_BYTE: begin
        w_misaligned = 1'b0;
        w_be         = 4'b0001 << mem_addr[1:0];
        w_wdata      = {4{mem_wdata[7:0]}};
      end
      c_SIZE_HALF: begin
        w_misaligned = mem_addr[0];
        w_be         = mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{mem_wdata[15:0]}};
      end
      default: begin
        w_misaligned = |mem_addr[1:0];
        w_be         = 4'b1111;
        w_wdata      = mem_wdata;
      end
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && mem_enable && !w_misaligned;
  assign stall    = w_accept || (r_state == ST_ACCESS);

  // Accepted accesses are aligned, so shifting by 8*offset right-aligns the
  // selected byte, the selected halfword (offset 0 or 2) and the word alike.
  assign w_lane_shift = dm_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_fmt = w_lane_shift;
    case (r_size)
      c_SIZE_BYTE: w_load_fmt = {{24{r_se & w_lane_shift[7]}},  w_lane_shift[7:0]};
      c_SIZE_HALF: w_load_fmt = {{16{r_se & w_lane_shift[15]}}, w_lane_shift[15:0]};
      default:     w_load_fmt = w_lane_shift;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_to_cnt;

  // Counts ACCESS cycles without ack; cleared on every entry to ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= 8'd0;
    end else if (w_accept) begin
      r_to_cnt <= 8'd0;
    end else if ((r_state == ST_ACCESS) && !dm_ack) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_to_cnt == c_TIMEOUT_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^c_TIMEOUT_LAST;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_off        <= 2'b00;
      r_size       <= 2'b00;
      r_se         <= 1'b0;
      r_rw         <= 1'b0;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= 32'd0;
      dm_wdata     <= 32'd0;
      dm_be        <= 4'd0;
      load_data    <= 32'd0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          load_valid <= 1'b0;
          if (mem_enable) begin
            if (w_misaligned) begin
              misalign_err <= 1'b1;
            end else begin
              r_off    <= mem_addr[1:0];
              r_size   <= mem_size;
              r_se     <= mem_se;
              r_rw     <= mem_rw;
              dm_req   <= 1'b1;
              dm_we    <= mem_rw;
              dm_addr  <= {mem_addr[31:2], 2'b00};
              dm_be    <= w_be;
              dm_wdata <= w_wdata;
              r_state  <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Ack on the terminal count still completes normally.
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (!r_rw) begin
              load_data  <= w_load_fmt;
              load_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            load_data   <= 32'd0;
            timeout_err <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          load_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
